div_retire_unit: RTL

DIV_RETIRE_UNIT -- requirements
Module: div_retire_unit

---
 rtl/div_retire_unit_pkg.sv | 23 ++
 rtl/div_retire_unit_if.sv | 42 ++++
 rtl/div_retire_fifo.sv | 84 ++++++++
 rtl/div_retire_unit.sv | 129 ++++++++++++
 4 files changed

// File: rtl/div_retire_unit_pkg.sv
// ============================================================================
// Module  : div_retire_unit_pkg
// Purpose : Shared types and defaults for the divide retire buffer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package div_retire_unit_pkg;

    localparam int REG_IDX_W       = 5;
    localparam int DATA_W          = 32;
    localparam int DEPTH_DEFAULT   = 4;
    localparam int DIV_LAT_DEFAULT = 8;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    data;
    } entry_t;

endpackage

`default_nettype wire

// File: rtl/div_retire_unit_if.sv
// ============================================================================
// Module  : div_retire_unit_if
// Purpose : Pipeline-side signal bundle of the divide retire unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface div_retire_unit_if;
    import div_retire_unit_pkg::*;

    logic                 div_issue;
    logic                 res_valid;
    logic                 res_get_rem;
    logic [REG_IDX_W-1:0] res_rd;
    logic [DATA_W-1:0]    div_quotient;
    logic [DATA_W-1:0]    div_remainder;
    logic                 w_reg_we;
    logic [REG_IDX_W-1:0] w_rd_addr;
    logic [REG_IDX_W-1:0] hz_rs1;
    logic [REG_IDX_W-1:0] hz_rs2;
    logic                 dw_we;
    logic [REG_IDX_W-1:0] dw_rd;
    logic [DATA_W-1:0]    dw_data;
    logic                 hz_rs1_hit;
    logic                 hz_rs2_hit;
    logic                 div_stall;

    modport master (
        output div_issue, res_valid, res_get_rem, res_rd, div_quotient, div_remainder,
        output w_reg_we, w_rd_addr, hz_rs1, hz_rs2,
        input  dw_we, dw_rd, dw_data, hz_rs1_hit, hz_rs2_hit, div_stall
    );

    modport slave (
        input  div_issue, res_valid, res_get_rem, res_rd, div_quotient, div_remainder,
        input  w_reg_we, w_rd_addr, hz_rs1, hz_rs2,
        output dw_we, dw_rd, dw_data, hz_rs1_hit, hz_rs2_hit, div_stall
    );

endinterface

`default_nettype wire

// File: rtl/div_retire_fifo.sv
// ============================================================================
// Module  : div_retire_fifo
// Purpose : Retire-buffer storage with wrap pointers, count and squash-by-rd.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_retire_fifo
    import div_retire_unit_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  wire logic                                 clk,
    input  wire logic                                 rst,
    input  wire logic                                 push_i,
    input  wire entry_t                               push_entry_i,
    input  wire logic                                 pop_i,
    input  wire logic                                 squash_i,
    input  wire logic [REG_IDX_W-1:0]                 squash_rd_i,
    output entry_t                                    head_o,
    output logic [DEPTH-1:0]                          valid_vec_o,
    output logic [DEPTH-1:0][REG_IDX_W-1:0]           rd_vec_o,
    output logic [CNT_W-1:0]                          count_o,
    output logic                                      empty_o,
    output logic                                      full_o
);

    entry_t           entries_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             w_push;
    logic             w_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign w_pop   = pop_i && !empty_o;
    assign w_push  = push_i && (!full_o || w_pop);

    // Squash first, then retire the head, then write the tail: when full the
    // tail slot is the one being popped, so the new entry must win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash_i && (entries_q[i].rd == squash_rd_i)) begin
                    entries_q[i].valid <= 1'b0;
                end
            end
            if (w_pop) begin
                entries_q[head_q].valid <= 1'b0;
                head_q                  <= head_q + PTR_W'(1);
            end
            if (w_push) begin
                entries_q[tail_q] <= push_entry_i;
                tail_q            <= tail_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = entries_q[head_q];
    assign count_o = count_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_tap
        assign valid_vec_o[g] = entries_q[g].valid;
        assign rd_vec_o[g]    = entries_q[g].rd;
    end

endmodule

`default_nettype wire

// File: rtl/div_retire_unit.sv
// ============================================================================
// Module  : div_retire_unit
// Purpose : Buffers divider results and retires them through the shared
//           register-file write port, with hazard and issue-credit tracking.
// Config  : DIV_RETIRE_BYPASS_EN - same-cycle write of a result when the
//           buffer is empty and the port is free.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_retire_unit
    import div_retire_unit_pkg::*;
#(
    parameter  int DEPTH   = DEPTH_DEFAULT,
    parameter  int DIV_LAT = DIV_LAT_DEFAULT,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    div_retire_unit_if.slave       div_if,
    output logic [CNT_W-1:0]       buf_count_o,
    output logic                   ovf_err_o
);

    localparam int INF_W = $clog2(DIV_LAT + 1);
    localparam int SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

    entry_t                          w_head;
    entry_t                          w_arr_entry;
    logic [DEPTH-1:0]                w_valid_vec;
    logic [DEPTH-1:0][REG_IDX_W-1:0] w_rd_vec;
    logic [CNT_W-1:0]                w_count;
    logic                            w_empty;
    logic                            w_full;
    logic                            w_push_req;
    logic                            w_wb_squash;
    logic                            w_bypass;
    logic                            w_head_write;
    logic                            w_pop;
    logic                            w_fifo_push;
    logic                            w_hit1;
    logic                            w_hit2;
    logic [INF_W-1:0]                inflight_q;
    logic [INF_W-1:0]                inflight_d;
    logic                            ovf_q;

    assign w_push_req  = div_if.res_valid && (div_if.res_rd != '0);
    assign w_wb_squash = div_if.w_reg_we && (div_if.w_rd_addr != '0);

    // A result landing while the main pipe writes the same rd is already stale.
    assign w_arr_entry.valid = !(w_wb_squash && (div_if.w_rd_addr == div_if.res_rd));
    assign w_arr_entry.rd    = div_if.res_rd;
    assign w_arr_entry.data  = div_if.res_get_rem ? div_if.div_remainder : div_if.div_quotient;

`ifdef DIV_RETIRE_BYPASS_EN
    assign w_bypass = w_push_req && w_empty && !div_if.w_reg_we && !rst;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_head_write = !w_empty && w_head.valid && !div_if.w_reg_we;
    assign w_pop        = !w_empty && (!w_head.valid || !div_if.w_reg_we);
    assign w_fifo_push  = w_push_req && !w_bypass;

    div_retire_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (w_fifo_push),
        .push_entry_i (w_arr_entry),
        .pop_i        (w_pop),
        .squash_i     (w_wb_squash),
        .squash_rd_i  (div_if.w_rd_addr),
        .head_o       (w_head),
        .valid_vec_o  (w_valid_vec),
        .rd_vec_o     (w_rd_vec),
        .count_o      (w_count),
        .empty_o      (w_empty),
        .full_o       (w_full)
    );

    assign div_if.dw_we   = !rst && (w_head_write || w_bypass);
    assign div_if.dw_rd   = w_bypass ? div_if.res_rd : w_head.rd;
    assign div_if.dw_data = w_bypass ? w_arr_entry.data : w_head.data;

    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid_vec[i] && (w_rd_vec[i] == div_if.hz_rs1)) w_hit1 = 1'b1;
            if (w_valid_vec[i] && (w_rd_vec[i] == div_if.hz_rs2)) w_hit2 = 1'b1;
        end
        if (div_if.res_valid && (div_if.res_rd == div_if.hz_rs1)) w_hit1 = 1'b1;
        if (div_if.res_valid && (div_if.res_rd == div_if.hz_rs2)) w_hit2 = 1'b1;
    end

    assign div_if.hz_rs1_hit = !rst && w_hit1 && (div_if.hz_rs1 != '0);
    assign div_if.hz_rs2_hit = !rst && w_hit2 && (div_if.hz_rs2 != '0);

    always_comb begin
        inflight_d = inflight_q;
        if (div_if.div_issue && !div_if.res_valid && (inflight_q != INF_W'(DIV_LAT))) begin
            inflight_d = inflight_q + INF_W'(1);
        end else if (!div_if.div_issue && div_if.res_valid && (inflight_q != '0)) begin
            inflight_d = inflight_q - INF_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            if (w_fifo_push && w_full && !w_pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Every in-flight divide is guaranteed a slot once its result lands.
    assign div_if.div_stall = (SUM_W'(w_count) + SUM_W'(inflight_q)) >= SUM_W'(DEPTH);
    assign buf_count_o      = w_count;
    assign ovf_err_o        = ovf_q;

endmodule

`default_nettype wire
